// File: rtl/regfile_sb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_pkg
//  Description : Shared constants and types for the regfile_sb register file.
//  Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int ZERO_REG  = 0;

    typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;
    typedef logic [XLEN_DEF-1:0]          word_t;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/regfile_sb_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_sb_if
//  Description : Read, write-back, issue and scoreboard signals between the
//                ID/WB stages (master) and the register file (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                we;
    logic [AW-1:0]       wa;
    logic [XLEN-1:0]     din;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic [NREGS-1:0]    busy_vec;
    logic                flush;

    modport master (
        output rd_addr, we, wa, din, iss_valid, iss_rd, flush,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_addr, we, wa, din, iss_valid, iss_rd, flush,
        output rd_data, rd_busy, busy_vec
    );

endinterface : regfile_sb_if
`default_nettype wire

// File: rtl/regfile_sb_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : rf_scoreboard
//  Description : One busy bit per architectural register. Issue sets, WB
//                clears, flush clears everything; register 0 never busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter  int NREGS = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_rd,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic             flush,
    output logic [NREGS-1:0] busy_vec
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;

    // Next busy state: flush dominates, then a new producer's set overrides
    // the retiring producer's clear (set applied after clear).
    always_comb begin
        w_busy_nxt = r_busy;
        if (flush) begin
            w_busy_nxt = '0;
        end else begin
            if (we) begin
                w_busy_nxt[wa] = 1'b0;
            end
            if (iss_valid) begin
                w_busy_nxt[iss_rd] = 1'b1;
            end
        end
        w_busy_nxt[ZERO_REG] = 1'b0;
    end

    // Scoreboard state, cleared asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign busy_vec = r_busy;

endmodule : rf_scoreboard
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_sb
//  Description : Parametrised register file with NRD combinational read
//                ports, one write port, optional write-to-read bypass and a
//                per-register busy scoreboard. Register 0 reads as zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb
    import rf_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEF,
    parameter  int NREGS  = NREGS_DEF,
    parameter  int NRD    = 2,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_sb_if.slave  bus
);

    localparam logic [AW-1:0] c_ZERO_ADDR = AW'(ZERO_REG);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] w_busy;

    // Architectural storage; entry 0 is never written so it stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (bus.we && (bus.wa != c_ZERO_ADDR)) begin
            r_regs[bus.wa] <= bus.din;
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (bus.iss_valid),
        .iss_rd    (bus.iss_rd),
        .we        (bus.we),
        .wa        (bus.wa),
        .flush     (bus.flush),
        .busy_vec  (w_busy)
    );

    assign bus.busy_vec = w_busy;

    // Read ports: a forwarded write also hides the busy bit, since the
    // consumer already receives the producer's value.
    generate
        for (genvar k = 0; k < NRD; k++) begin : g_rd
            logic [AW-1:0] w_addr;
            logic          w_zero;
            logic          w_hit;

            assign w_addr = bus.rd_addr[k*AW +: AW];
            assign w_zero = (w_addr == c_ZERO_ADDR);
            assign w_hit  = (BYPASS != 0) && bus.we && (bus.wa == w_addr) && !w_zero;

            assign bus.rd_data[k*XLEN +: XLEN] = w_zero ? '0 :
                                                 w_hit  ? bus.din : r_regs[w_addr];
            assign bus.rd_busy[k] = w_hit ? 1'b0 : w_busy[w_addr];
        end
    endgenerate

endmodule : regfile_sb
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_sb
//  Description : Bench for regfile_sb: a 4-port bypassing instance and a
//                2-port non-bypassing instance driven with identical writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;
    import rf_pkg::*;

    logic clk;
    logic rst_n;

    regfile_sb_if #(.XLEN(32), .NREGS(32), .NRD(4)) if_a ();
    regfile_sb_if #(.XLEN(32), .NREGS(32), .NRD(2)) if_b ();

    regfile_sb #(.XLEN(32), .NREGS(32), .NRD(4), .BYPASS(1)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a)
    );

    regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_err = 0;
    word_t reg_m  [32];
    bit    busy_m [32];

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            reg_m[i]  = '0;
            busy_m[i] = 1'b0;
        end
    endfunction

    // Value a read port must show this cycle.
    function automatic word_t exp_data(reg_addr_t a, bit byp);
        if (a == 0) return '0;
        if (byp && if_a.we && if_a.wa == a) return if_a.din;
        return reg_m[a];
    endfunction

    function automatic bit exp_busy(reg_addr_t a, bit byp);
        if (a == 0) return 1'b0;
        if (byp && if_a.we && if_a.wa == a) return 1'b0;
        return busy_m[a];
    endfunction

    function automatic logic [31:0] exp_bv();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = busy_m[i];
        return v;
    endfunction

    task automatic drv(input bit we, input reg_addr_t wa, input word_t din,
                       input bit iv, input reg_addr_t ird, input bit fl);
        if_a.we = we; if_a.wa = wa; if_a.din = din;
        if_a.iss_valid = iv; if_a.iss_rd = ird; if_a.flush = fl;
        if_b.we = we; if_b.wa = wa; if_b.din = din;
        if_b.iss_valid = iv; if_b.iss_rd = ird; if_b.flush = fl;
    endtask

    task automatic set_a(input int k, input reg_addr_t a);
        if_a.rd_addr[k*5 +: 5] = a;
    endtask

    task automatic set_b(input int k, input reg_addr_t a);
        if_b.rd_addr[k*5 +: 5] = a;
    endtask

    // Advance one clock, applying the architectural rules to the model.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (if_a.we && if_a.wa != 0) reg_m[if_a.wa] = if_a.din;
            if (if_a.flush) begin
                for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
            end else begin
                if (if_a.we && if_a.wa != 0) busy_m[if_a.wa] = 1'b0;
                if (if_a.iss_valid && if_a.iss_rd != 0) busy_m[if_a.iss_rd] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        drv(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) set_a(k, reg_addr_t'($urandom_range(31)));
        for (int k = 0; k < 2; k++) set_b(k, reg_addr_t'($urandom_range(31)));
        #3;
        n_cmp++;
        if (if_a.rd_data !== 128'd0 || if_a.rd_busy !== 4'd0) begin
            n_err++;
            $display("FAIL reset_read_a: data=%h busy=%b want 0", if_a.rd_data, if_a.rd_busy);
        end
        n_cmp++;
        if (if_a.busy_vec !== 32'd0 || if_b.busy_vec !== 32'd0) begin
            n_err++;
            $display("FAIL reset_busy_vec: a=%h b=%h want 0", if_a.busy_vec, if_b.busy_vec);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_zero_reg();
        drv(1, 5, 32'hDEADBEEF, 1, 6, 0);
        tick();
        drv(0, 0, 0, 0, 0, 0);
        set_a(0, 5); set_b(0, 5);
        #2;
        n_cmp++;
        if (if_a.rd_data[31:0] !== 32'hDEADBEEF || if_a.busy_vec !== 32'h0000_0040) begin
            n_err++;
            $display("FAIL x5_written: data=%h bv=%h want deadbeef/00000040",
                     if_a.rd_data[31:0], if_a.busy_vec);
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if (if_a.rd_data[31:0] !== 32'd0 || if_b.rd_data[31:0] !== 32'd0 ||
            if_a.busy_vec !== 32'd0 || if_b.busy_vec !== 32'd0) begin
            n_err++;
            $display("FAIL async_reset: a=%h b=%h bva=%h bvb=%h want 0",
                     if_a.rd_data[31:0], if_b.rd_data[31:0], if_a.busy_vec, if_b.busy_vec);
        end
        rst_n = 1'b1;
        drv(1, 0, 32'hFFFFFFFF, 1, 0, 0);
        set_a(0, 0); set_a(1, 0);
        #2;
        n_cmp++;
        if (if_a.rd_data[63:0] !== 64'd0 || if_a.rd_busy[1:0] !== 2'b00) begin
            n_err++;
            $display("FAIL x0_bypass: data=%h busy=%b want 0", if_a.rd_data[63:0], if_a.rd_busy[1:0]);
        end
        tick();
        drv(0, 0, 0, 0, 0, 0);
        #2;
        n_cmp++;
        if (if_a.rd_data[31:0] !== 32'd0 || if_a.busy_vec !== 32'd0) begin
            n_err++;
            $display("FAIL x0_after_write: data=%h bv=%h want 0", if_a.rd_data[31:0], if_a.busy_vec);
        end
    endtask

    task automatic test_bypass();
        drv(1, 7, 32'h12345678, 0, 0, 0);
        set_a(0, 7); set_b(0, 7);
        #2;
        n_cmp++;
        if (if_a.rd_data[31:0] !== 32'h12345678) begin
            n_err++;
            $display("FAIL bypass_on: got %h want 12345678", if_a.rd_data[31:0]);
        end
        n_cmp++;
        if (if_b.rd_data[31:0] !== 32'd0) begin
            n_err++;
            $display("FAIL bypass_off_before: got %h want 00000000", if_b.rd_data[31:0]);
        end
        tick();
        drv(0, 0, 0, 0, 0, 0);
        #2;
        n_cmp++;
        if (if_b.rd_data[31:0] !== 32'h12345678) begin
            n_err++;
            $display("FAIL bypass_off_after: got %h want 12345678", if_b.rd_data[31:0]);
        end
    endtask

    task automatic test_scoreboard();
        drv(0, 0, 0, 1, 3, 0);
        tick();
        drv(0, 0, 0, 0, 0, 0);
        set_a(0, 3); set_b(0, 3);
        #2;
        n_cmp++;
        if (if_a.busy_vec[3] !== 1'b1 || if_a.rd_busy[0] !== 1'b1 || if_b.rd_busy[0] !== 1'b1) begin
            n_err++;
            $display("FAIL sb_set: bv3=%b a_busy=%b b_busy=%b want 1/1/1",
                     if_a.busy_vec[3], if_a.rd_busy[0], if_b.rd_busy[0]);
        end
        drv(1, 3, 32'h000000A5, 0, 0, 0);
        #2;
        n_cmp++;
        if (if_a.rd_busy[0] !== 1'b0 || if_a.rd_data[31:0] !== 32'h000000A5) begin
            n_err++;
            $display("FAIL sb_fwd: busy=%b data=%h want 0/000000a5", if_a.rd_busy[0], if_a.rd_data[31:0]);
        end
        n_cmp++;
        if (if_b.rd_busy[0] !== 1'b1 || if_b.rd_data[31:0] !== 32'd0) begin
            n_err++;
            $display("FAIL sb_nofwd: busy=%b data=%h want 1/00000000", if_b.rd_busy[0], if_b.rd_data[31:0]);
        end
        tick();
        drv(0, 0, 0, 0, 0, 0);
        #2;
        n_cmp++;
        if (if_a.busy_vec[3] !== 1'b0 || if_b.busy_vec[3] !== 1'b0) begin
            n_err++;
            $display("FAIL sb_clear: a=%b b=%b want 0", if_a.busy_vec[3], if_b.busy_vec[3]);
        end
    endtask

    task automatic test_set_clear();
        drv(0, 0, 0, 1, 9, 0);
        tick();
        drv(1, 9, 32'hCAFEF00D, 1, 9, 0);
        tick();
        drv(0, 0, 0, 0, 0, 0);
        set_b(0, 9);
        #2;
        n_cmp++;
        if (if_b.rd_data[31:0] !== 32'hCAFEF00D || if_a.busy_vec[9] !== 1'b1 || if_b.rd_busy[0] !== 1'b1) begin
            n_err++;
            $display("FAIL set_over_clear: data=%h bv9=%b busy=%b want cafef00d/1/1",
                     if_b.rd_data[31:0], if_a.busy_vec[9], if_b.rd_busy[0]);
        end
    endtask

    task automatic test_flush();
        drv(0, 0, 0, 1, 1, 0);  tick();
        drv(0, 0, 0, 1, 2, 0);  tick();
        drv(0, 0, 0, 1, 31, 0); tick();
        drv(0, 0, 0, 0, 0, 0);
        #2;
        n_cmp++;
        if (if_a.busy_vec !== 32'h8000_0206) begin
            n_err++;
            $display("FAIL flush_pre: got %h want 80000206", if_a.busy_vec);
        end
        drv(1, 12, 32'h0BADC0DE, 1, 4, 1);
        tick();
        drv(0, 0, 0, 0, 0, 0);
        set_b(0, 4); set_b(1, 12);
        #2;
        n_cmp++;
        if (if_a.busy_vec !== 32'd0 || if_b.busy_vec !== 32'd0 || if_b.rd_busy[0] !== 1'b0) begin
            n_err++;
            $display("FAIL flush_busy: a=%h b=%h x4=%b want 0", if_a.busy_vec, if_b.busy_vec, if_b.rd_busy[0]);
        end
        n_cmp++;
        if (if_b.rd_data[63:32] !== 32'h0BADC0DE) begin
            n_err++;
            $display("FAIL flush_write: got %h want 0badc0de", if_b.rd_data[63:32]);
        end
    endtask

    task automatic test_multiport();
        word_t     r31;
        reg_addr_t mix [4];
        word_t     want;
        r31 = word_t'($urandom);
        mix[0] = 0; mix[1] = 10; mix[2] = 31; mix[3] = 10;
        drv(1, 10, 32'h55AA55AA, 0, 0, 0); tick();
        drv(1, 31, r31, 0, 0, 0);          tick();
        drv(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) set_a(k, 10);
        #2;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (if_a.rd_data[k*32 +: 32] !== 32'h55AA55AA) begin
                n_err++;
                $display("FAIL mp_same[%0d]: got %h want 55aa55aa", k, if_a.rd_data[k*32 +: 32]);
            end
        end
        for (int k = 0; k < 4; k++) set_a(k, mix[k]);
        #2;
        for (int k = 0; k < 4; k++) begin
            want = (k == 0) ? 32'd0 : (k == 2) ? r31 : 32'h55AA55AA;
            n_cmp++;
            if (if_a.rd_data[k*32 +: 32] !== want) begin
                n_err++;
                $display("FAIL mp_mixed[%0d]: got %h want %h", k, if_a.rd_data[k*32 +: 32], want);
            end
        end
    endtask

    task automatic test_random();
        reg_addr_t wa;
        reg_addr_t a;
        for (int c = 0; c < 300; c++) begin
            wa = reg_addr_t'($urandom_range(31));
            drv(bit'($urandom_range(1)), wa, word_t'($urandom), bit'($urandom_range(1)),
                reg_addr_t'($urandom_range(31)), ($urandom_range(15) == 0));
            for (int k = 0; k < 4; k++) begin
                a = ($urandom_range(3) == 0) ? wa : reg_addr_t'($urandom_range(31));
                set_a(k, a);
            end
            for (int k = 0; k < 2; k++) begin
                a = ($urandom_range(3) == 0) ? wa : reg_addr_t'($urandom_range(31));
                set_b(k, a);
            end
            #2;
            for (int k = 0; k < 4; k++) begin
                a = if_a.rd_addr[k*5 +: 5];
                n_cmp++;
                if (if_a.rd_data[k*32 +: 32] !== exp_data(a, 1'b1) || if_a.rd_busy[k] !== exp_busy(a, 1'b1)) begin
                    n_err++;
                    $display("FAIL rand_a c=%0d p=%0d x%0d: data=%h busy=%b want %h/%b", c, k, a,
                             if_a.rd_data[k*32 +: 32], if_a.rd_busy[k], exp_data(a, 1'b1), exp_busy(a, 1'b1));
                end
            end
            for (int k = 0; k < 2; k++) begin
                a = if_b.rd_addr[k*5 +: 5];
                n_cmp++;
                if (if_b.rd_data[k*32 +: 32] !== exp_data(a, 1'b0) || if_b.rd_busy[k] !== exp_busy(a, 1'b0)) begin
                    n_err++;
                    $display("FAIL rand_b c=%0d p=%0d x%0d: data=%h busy=%b want %h/%b", c, k, a,
                             if_b.rd_data[k*32 +: 32], if_b.rd_busy[k], exp_data(a, 1'b0), exp_busy(a, 1'b0));
                end
            end
            n_cmp++;
            if (if_a.busy_vec !== exp_bv() || if_b.busy_vec !== exp_bv()) begin
                n_err++;
                $display("FAIL rand_bv c=%0d: a=%h b=%h want %h", c, if_a.busy_vec, if_b.busy_vec, exp_bv());
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_zero_reg();
        test_bypass();
        test_scoreboard();
        test_set_clear();
        test_flush();
        test_multiport();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_regfile_sb
`default_nettype wire
